crc_frame_checker: RTL and testbench
====================================

Name: crc_frame_checker

Overview:
- Receive end of the switch-to-LED CRC path: accepts a bit-serial frame of DATA_W data bits followed by CRC_W CRC bits, MSB first.
- Reassembles the data word, recomputes the CRC with a bit-serial LFSR and flags pass/fail.
- Presents the captured word and status to the LED/display logic in the top level.
- CRC model: non-reflected, init all-zeros, no final XOR. The receiver checks the residue, so the LFSR is zero after a good frame.

Parameters:
- DATA_W, 16, payload bits per frame.
- CRC_W, 8, CRC bits per frame.
- POLY, 8'h07, generator polynomial without the implicit top bit (CRC-8/ATM).

Ports:
- CLK  input  1  system clock; all logic rising-edge.
- RESET  input  1  synchronous, active-high reset.
- SDATA  input  1  serial bit, valid when SVALID=1.
- SVALID  input  1  qualifies SDATA; one bit is consumed per cycle with SVALID=1.
- SSTART  input  1  frame-start marker; meaningful only with SVALID=1; marks the first data bit.
- DATA_OUT  output  DATA_W  last completed frame payload.
- CRC_OK  output  1  1 if the last completed frame had zero residue.
- FRAME_DONE  output  1  single-cycle pulse when DATA_OUT/CRC_OK update.
- BUSY  output  1  high while in RX_DATA or RX_CRC.

Behaviour:
- Reset (synchronous, RESET=1 at the clock edge): state=IDLE, LFSR=0, bit counter=0, shift register=0, DATA_OUT=0, CRC_OK=0, FRAME_DONE=0, BUSY=0. Reset asserted mid-frame discards the frame with no FRAME_DONE.
- LFSR step per accepted bit b: fb = lfsr[CRC_W-1]^b; lfsr = {lfsr[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
- IDLE: SVALID&SSTART loads LFSR with the step of bit0 from 0, shifts bit0 into the data register, count=1, goes to RX_DATA. SVALID bits without SSTART are ignored.
- RX_DATA:
  - Each SVALID bit is shifted into the data register (MSB first) and stepped into the LFSR; count increments.
  - When the DATA_W-th bit is accepted: go to RX_CRC, count=0.
- RX_CRC:
  - Each SVALID bit is stepped into the LFSR only.
  - On the CRC_W-th bit: go to DONE.
- DONE (one cycle):
  - DATA_OUT <= data register.
  - CRC_OK <= (LFSR==0).
  - FRAME_DONE=1.
  - Return to IDLE.
  - FRAME_DONE therefore asserts exactly one cycle after the edge that accepts the last CRC bit.
- Gaps: SVALID=0 holds all state in every state; there is no timeout.
- Resync: SVALID&SSTART in RX_DATA or RX_CRC aborts the current frame with no FRAME_DONE. That bit is treated as bit0 of a new frame (same action as IDLE).
- SSTART in DONE: DONE completes normally. The bit is accepted as bit0 of a new frame in the same cycle, giving back-to-back frames with no lost bit.
- DATA_OUT and CRC_OK hold between frames; they change only in DONE.
- BUSY is registered and equals (state==RX_DATA||state==RX_CRC).

Optional Feature:
- Macro CRC_ERR_CNT_EN.
- Defined:
  - Adds output ERR_COUNT [7:0].
  - Increments in DONE when the LFSR is nonzero.
  - Saturates at 8'hFF.
  - Cleared by RESET only.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package crc_pkg holds:
  - typedef enum logic [1:0] {IDLE, RX_DATA, RX_CRC, DONE} crc_rx_state_t;
  - CRC8_POLY = 8'h07;
  - function crc_step(lfsr, bit, poly), shared with the transmit-side CRC calculator so both ends use one definition.
- One sub-module, crc_lfsr_step: combinational single-bit LFSR update, parameterised by CRC_W/POLY.
- The FSM, counters and data shift register stay in crc_frame_checker.

Test Plan:
- Reset, then send 0x1234 followed by CRC 0xF1 with SVALID continuous -> FRAME_DONE pulse 1 cycle after last bit; DATA_OUT=0x1234, CRC_OK=1.
- Send 0x1234 with CRC 0xF0 -> DATA_OUT=0x1234, CRC_OK=0. With CRC_ERR_CNT_EN defined, ERR_COUNT=1.
- Send 0x0000 with CRC 0x00, SVALID deasserted for 3 cycles after every 4th bit -> CRC_OK=1, DATA_OUT=0x0000, exactly one FRAME_DONE. BUSY is high throughout the gaps.
- Abort 10 bits into a frame with a new SSTART frame 0x1234/0xF1 -> no FRAME_DONE for the aborted frame; DATA_OUT=0x1234, CRC_OK=1.
- Assert RESET for 1 cycle during the CRC bits of a frame -> no FRAME_DONE, outputs at reset values, next complete good frame passes.
- Two back-to-back frames 0x1234/0xF1 then 0xABCD with a deliberately wrong CRC, with SSTART of the second frame in the DONE cycle -> two FRAME_DONE pulses. CRC_OK=1 then 0; DATA_OUT=0x1234 then 0xABCD.

Source files
------------

// File: rtl/crc_frame_checker_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the serial CRC link: receiver state encoding, the
// CRC-8/ATM generator polynomial and the single-bit LFSR update used by both
// the transmit-side CRC calculator and the receive-side frame checker.
//
// Contents:
//   crc_rx_state_t  receiver FSM states
//   CRC8_W          CRC width of the standard link
//   CRC8_POLY       generator polynomial without the implicit top bit
//   crc_step()      one LFSR step for one serial bit, MSB first
// -----------------------------------------------------------------------------
package crc_pkg;

    typedef enum logic [1:0] {IDLE, RX_DATA, RX_CRC, DONE} crc_rx_state_t;

    localparam int          CRC8_W    = 8;
    localparam logic [7:0]  CRC8_POLY = 8'h07;

    // Non-reflected shift: the outgoing top bit is XORed with the incoming
    // serial bit, and the polynomial is folded back in when that is set.
    function automatic logic [CRC8_W-1:0] crc_step(
        input logic [CRC8_W-1:0] lfsr,
        input logic              din,
        input logic [CRC8_W-1:0] poly
    );
        logic fb;
        fb = lfsr[CRC8_W-1] ^ din;
        return {lfsr[CRC8_W-2:0], 1'b0} ^ (fb ? poly : {CRC8_W{1'b0}});
    endfunction

endpackage

// File: rtl/crc_frame_checker_if.sv
// -----------------------------------------------------------------------------
// crc_frame_checker_if
// Bundles the serial input side and the result side of the CRC frame checker.
//
// Signals:
//   SDATA       serial bit, qualified by SVALID
//   SVALID      one bit consumed per cycle while high
//   SSTART      marks the first data bit of a frame (with SVALID)
//   DATA_OUT    payload of the last completed frame
//   CRC_OK      1 when the last completed frame had zero residue
//   FRAME_DONE  single-cycle pulse when DATA_OUT/CRC_OK update
//   BUSY        high while a frame is being received
//
// Modports:
//   master  the bit source / result consumer (top level, testbench)
//   slave   the frame checker itself
// -----------------------------------------------------------------------------
interface crc_frame_checker_if #(
    parameter int DATA_W = 16
);

    logic              SDATA;
    logic              SVALID;
    logic              SSTART;
    logic [DATA_W-1:0] DATA_OUT;
    logic              CRC_OK;
    logic              FRAME_DONE;
    logic              BUSY;

    modport master (
        output SDATA, SVALID, SSTART,
        input  DATA_OUT, CRC_OK, FRAME_DONE, BUSY
    );

    modport slave (
        input  SDATA, SVALID, SSTART,
        output DATA_OUT, CRC_OK, FRAME_DONE, BUSY
    );

endinterface

// File: rtl/crc_frame_checker_lfsr_step.sv
// -----------------------------------------------------------------------------
// crc_lfsr_step
// Combinational single-bit LFSR update for an MSB-first, non-reflected CRC.
// For the 8-bit link the shared package function is used so that the
// transmitter and receiver cannot drift apart; other widths use the same
// equation written generically.
//
// Parameters:
//   CRC_W   CRC register width
//   POLY    generator polynomial without the implicit top bit
// Ports:
//   i_lfsr  current LFSR value
//   i_bit   serial bit being absorbed
//   o_lfsr  LFSR value after absorbing i_bit
// -----------------------------------------------------------------------------
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int               CRC_W = CRC8_W,
    parameter logic [CRC_W-1:0] POLY  = CRC8_POLY
) (
    input  logic [CRC_W-1:0] i_lfsr,
    input  logic             i_bit,
    output logic [CRC_W-1:0] o_lfsr
);

    generate
        if (CRC_W == CRC8_W) begin : g_shared
            assign o_lfsr = crc_step(i_lfsr, i_bit, POLY);
        end else begin : g_generic
            logic w_fb;
            assign w_fb   = i_lfsr[CRC_W-1] ^ i_bit;
            assign o_lfsr = {i_lfsr[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : {CRC_W{1'b0}});
        end
    endgenerate

endmodule

// File: rtl/crc_frame_checker.sv
// -----------------------------------------------------------------------------
// crc_frame_checker
// Receive end of the switch-to-LED CRC path. Takes a bit-serial frame of
// DATA_W payload bits followed by CRC_W CRC bits (MSB first), reassembles the
// payload, runs every bit through a bit-serial LFSR and reports pass/fail.
// A good frame leaves a zero residue in the LFSR (init 0, no final XOR).
//
// Optional feature (macro CRC_ERR_CNT_EN): adds ERR_COUNT, a saturating
// count of failed frames, cleared only by RESET.
//
// Parameters:
//   DATA_W  payload bits per frame
//   CRC_W   CRC bits per frame
//   POLY    generator polynomial without the implicit top bit
// Ports:
//   CLK        system clock, rising edge
//   RESET      synchronous active-high reset
//   ERR_COUNT  failed-frame count (only with CRC_ERR_CNT_EN)
//   bus        slave side of crc_frame_checker_if (serial in, results out)
// -----------------------------------------------------------------------------
module crc_frame_checker
    import crc_pkg::*;
#(
    parameter int               DATA_W = 16,
    parameter int               CRC_W  = CRC8_W,
    parameter logic [CRC_W-1:0] POLY   = CRC8_POLY
) (
    input  logic                CLK,
    input  logic                RESET,
`ifdef CRC_ERR_CNT_EN
    output logic [7:0]          ERR_COUNT,
`endif
    crc_frame_checker_if.slave  bus
);

    localparam int MAX_W = (DATA_W > CRC_W) ? DATA_W : CRC_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

    crc_rx_state_t     r_state;
    crc_rx_state_t     w_next_state;

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [CRC_W-1:0]  r_lfsr;
    logic [DATA_W-1:0] r_data_out;
    logic              r_crc_ok;
    logic              r_frame_done;
    logic              r_busy;

    logic              w_start;
    logic              w_load_first;
    logic              w_shift_data;
    logic              w_step_crc;
    logic              w_complete;
    logic [CRC_W-1:0]  w_lfsr_in;
    logic [CRC_W-1:0]  w_lfsr_next;

    // A start marker wins in every state: it either opens a frame from idle,
    // resynchronises mid-frame, or chains a new frame onto the DONE cycle.
    assign w_start = bus.SVALID && bus.SSTART;

    // The first bit of a frame is stepped from an all-zero register so any
    // residue of an aborted frame is thrown away.
    assign w_lfsr_in = w_start ? {CRC_W{1'b0}} : r_lfsr;

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_lfsr_step (
        .i_lfsr (w_lfsr_in),
        .i_bit  (bus.SDATA),
        .o_lfsr (w_lfsr_next)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. SVALID low simply holds the current state, so gaps in
    // the serial stream are tolerated indefinitely.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_start) begin
                    w_next_state = RX_DATA;
                end else if (bus.SVALID && (r_cnt == DATA_LAST)) begin
                    w_next_state = RX_CRC;
                end
            end
            RX_CRC: begin
                if (w_start) begin
                    w_next_state = RX_DATA;
                end else if (bus.SVALID && (r_cnt == CRC_LAST)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = w_start ? RX_DATA : IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output/control decode: which datapath action this cycle performs.
    // Plain data bits only count when no start marker is present.
    always_comb begin
        w_load_first = w_start;
        w_shift_data = !w_start && bus.SVALID && (r_state == RX_DATA);
        w_step_crc   = !w_start && bus.SVALID && (r_state == RX_CRC);
        w_complete   = (r_state == DONE);
    end

    // Datapath: bit counter, payload shift register, LFSR and the registered
    // result outputs. The result registers read the old shift/LFSR contents,
    // so a new frame starting in the DONE cycle does not disturb the result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_lfsr       <= '0;
            r_data_out   <= '0;
            r_crc_ok     <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if (w_load_first) begin
                r_shift <= {r_shift[DATA_W-2:0], bus.SDATA};
                r_lfsr  <= w_lfsr_next;
                r_cnt   <= CNT_W'(1);
            end else if (w_shift_data) begin
                r_shift <= {r_shift[DATA_W-2:0], bus.SDATA};
                r_lfsr  <= w_lfsr_next;
                r_cnt   <= (r_cnt == DATA_LAST) ? '0 : r_cnt + CNT_W'(1);
            end else if (w_step_crc) begin
                r_lfsr  <= w_lfsr_next;
                r_cnt   <= (r_cnt == CRC_LAST) ? '0 : r_cnt + CNT_W'(1);
            end

            if (w_complete) begin
                r_data_out <= r_shift;
                r_crc_ok   <= (r_lfsr == {CRC_W{1'b0}});
            end

            r_frame_done <= w_complete;
            r_busy       <= (w_next_state == RX_DATA) || (w_next_state == RX_CRC);
        end
    end

`ifdef CRC_ERR_CNT_EN
    logic [7:0] r_err_count;

    // Failed-frame counter; sticks at 8'hFF instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_err_count <= 8'h00;
        end else if (w_complete && (r_lfsr != {CRC_W{1'b0}}) && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'h01;
        end
    end

    assign ERR_COUNT = r_err_count;
`endif

    assign bus.DATA_OUT   = r_data_out;
    assign bus.CRC_OK     = r_crc_ok;
    assign bus.FRAME_DONE = r_frame_done;
    assign bus.BUSY       = r_busy;

endmodule

// File: tb/tb_crc_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_crc_frame_checker
// Scoreboard testbench for crc_frame_checker. The driver sends directed frames
// and pushes the hand-computed result (payload, CRC_OK, error count and the
// cycle the FRAME_DONE pulse must appear in) into a queue; a monitor pops and
// compares whenever FRAME_DONE is seen. Honours CRC_ERR_CNT_EN if defined.
//
// Hand-computed CRC-8/ATM values: crc(0x1234)=0xF1, crc(0x0000)=0x00,
// crc(0xABCD)=0xE2 (so 0x00 is a wrong CRC for 0xABCD).
// -----------------------------------------------------------------------------
module tb_crc_frame_checker;

    import crc_pkg::*;

    typedef struct {
        logic [15:0] data;
        logic        ok;
        int          err;
        int          doneCycle;
    } expect_t;

    logic    CLK;
    logic    RESET;
    logic [7:0] errCount;
    int      cycle;
    int      nTests;
    int      nFail;
    int      expErr;
    expect_t sbQ[$];

    crc_frame_checker_if #(.DATA_W(16)) bus ();

    crc_frame_checker #(
        .DATA_W (16),
        .CRC_W  (8),
        .POLY   (8'h07)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
`ifdef CRC_ERR_CNT_EN
        .ERR_COUNT (errCount),
`endif
        .bus       (bus)
    );

`ifndef CRC_ERR_CNT_EN
    assign errCount = 8'h00;
`endif

    // 100 MHz-style free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Edge counter used to time-stamp accepted bits and FRAME_DONE pulses.
    always @(posedge CLK) begin
        cycle <= cycle + 1;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK); #1;
        end
    endtask

    // Sends the first nBits of {data, crc} MSB first. Optional gaps of gapLen
    // idle cycles follow every gapEvery-th bit (never after the last one),
    // during which BUSY must stay high. A complete frame pushes its expected
    // result. Returns with SVALID low but without consuming a clock, so two
    // consecutive calls produce back-to-back frames.
    task automatic applyStimulus(input logic [15:0] data, input logic [7:0] crc, input int nBits,
                                 input int gapEvery, input int gapLen, input logic expOk);
        logic [23:0] frame;
        expect_t     e;
        frame = {data, crc};
        for (int i = 0; i < nBits; i++) begin
            bus.SVALID = 1'b1;
            bus.SSTART = (i == 0);
            bus.SDATA  = frame[23-i];
            @(posedge CLK); #1;
            bus.SVALID = 1'b0;
            bus.SSTART = 1'b0;
            if (gapEvery > 0 && ((i + 1) % gapEvery) == 0 && (i + 1) < nBits) begin
                for (int g = 0; g < gapLen; g++) begin
                    @(posedge CLK); #1;
                    checkOutput("busy_in_gap", {31'd0, bus.BUSY}, 32'd1);
                end
            end
        end
        if (nBits == 24) begin
            if (!expOk && expErr < 255) begin
                expErr++;
            end
            e.data      = data;
            e.ok        = expOk;
            e.err       = expErr;
            e.doneCycle = cycle + 1;
            sbQ.push_back(e);
        end
    endtask

    task automatic pulseReset(input int n);
        RESET = 1'b1;
        idle(n);
        RESET = 1'b0;
        expErr = 0;
    endtask

    // Monitor: compares every FRAME_DONE against the scoreboard head, flags
    // pulses nobody expected and expected pulses that never arrived.
    always @(negedge CLK) begin
        expect_t e;
        if (!RESET && bus.FRAME_DONE === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("frame_done_cycle", cycle, e.doneCycle);
                checkOutput("data_out", {16'd0, bus.DATA_OUT}, {16'd0, e.data});
                checkOutput("crc_ok", {31'd0, bus.CRC_OK}, {31'd0, e.ok});
`ifdef CRC_ERR_CNT_EN
                checkOutput("err_count", {24'd0, errCount}, e.err);
`endif
            end
        end else if (sbQ.size() > 0 && cycle > sbQ[0].doneCycle) begin
            e = sbQ.pop_front();
            checkOutput("missing_frame_done", 32'd0, 32'd1);
        end
    end

    // Directed test sequence.
    initial begin
        cycle      = 0;
        nTests     = 0;
        nFail      = 0;
        expErr     = 0;
        RESET      = 1'b1;
        bus.SDATA  = 1'b0;
        bus.SVALID = 1'b0;
        bus.SSTART = 1'b0;

        // Reset values.
        idle(2);
        RESET = 1'b0;
        idle(1);
        checkOutput("reset_data_out", {16'd0, bus.DATA_OUT}, 32'h0);
        checkOutput("reset_crc_ok", {31'd0, bus.CRC_OK}, 32'd0);
        checkOutput("reset_frame_done", {31'd0, bus.FRAME_DONE}, 32'd0);
        checkOutput("reset_busy", {31'd0, bus.BUSY}, 32'd0);

        // Stray bits without a start marker are ignored.
        bus.SVALID = 1'b1; bus.SDATA = 1'b1;
        idle(3);
        bus.SVALID = 1'b0;
        checkOutput("idle_ignores_bits", {31'd0, bus.BUSY}, 32'd0);

        // Good frame, continuous.
        applyStimulus(16'h1234, 8'hF1, 24, 0, 0, 1'b1);
        idle(4);

        // Corrupted CRC.
        applyStimulus(16'h1234, 8'hF0, 24, 0, 0, 1'b0);
        idle(4);
        checkOutput("data_out_holds", {16'd0, bus.DATA_OUT}, 32'h1234);

        // All-zero frame with gaps after every 4th bit.
        applyStimulus(16'h0000, 8'h00, 24, 4, 3, 1'b1);
        checkOutput("busy_low_in_done", {31'd0, bus.BUSY}, 32'd0);
        idle(4);

        // Abort 10 bits in with a new good frame.
        applyStimulus(16'hFFFF, 8'h00, 10, 0, 0, 1'b0);
        applyStimulus(16'h1234, 8'hF1, 24, 0, 0, 1'b1);
        idle(4);

        // Reset during the CRC bits: frame dropped, outputs back to reset values.
        applyStimulus(16'hABCD, 8'hE2, 20, 0, 0, 1'b1);
        pulseReset(1);
        checkOutput("midreset_data_out", {16'd0, bus.DATA_OUT}, 32'h0);
        checkOutput("midreset_crc_ok", {31'd0, bus.CRC_OK}, 32'd0);
        checkOutput("midreset_busy", {31'd0, bus.BUSY}, 32'd0);
`ifdef CRC_ERR_CNT_EN
        checkOutput("midreset_err_count", {24'd0, errCount}, 32'd0);
`endif
        idle(3);
        applyStimulus(16'hABCD, 8'hE2, 24, 0, 0, 1'b1);
        idle(4);

        // Back-to-back: second SSTART lands in the DONE cycle of the first.
        applyStimulus(16'h1234, 8'hF1, 24, 0, 0, 1'b1);
        applyStimulus(16'hABCD, 8'h00, 24, 0, 0, 1'b0);
        idle(6);

        checkOutput("scoreboard_drained", sbQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
